clb_multi_ble: RTL and testbench
================================

// Module: clb_multi_ble
// PURPOSE
//   Parametrised configurable logic block: CLB_BLE_NUM basic logic elements (BLEs), each a LUT_K-input LUT.
//   Each BLE output is either combinational or registered, with a programmable FF init value.
//   A full crossbar feeds every LUT input from the CLB inputs, from the BLE FF feedback, or from constant 0.
//   Configuration is scanned into a shadow chain while the active configuration keeps running.
//   An explicit commit then loads the shadow into the active configuration atomically.
//   The block sits in the FPGA fabric tile and is chained with other tiles through scan_in/scan_out.
// PARAMETERS
//   CLB_IN_WIDTH  10  number of general CLB inputs (I)
//   CLB_BLE_NUM   4   number of BLEs / outputs (N)
//   LUT_K         4   LUT input count (K); LUT table is 2**K bits
//   SEL_W  (local) $clog2(I+N+1)            crossbar select width (defaults: 4)
//   CFG_BITS (local) N*2**K + N*K*SEL_W + 2*N  total chain length (defaults: 136)
// PORTS
//   clk         in   1     single clock, all state on posedge
//   rst_n       in   1     asynchronous active-low reset
//   clb_in      in   I     user logic inputs
//   ce          in   1     clock enable for BLE flip-flops
//   out         out  N     BLE outputs, bit b = BLE b
//   scan_en     in   1     shift shadow chain one bit per cycle
//   scan_in     in   1     chain serial input
//   scan_out    out  1     chain serial output (= shadow[CFG_BITS-1])
//   cfg_commit  in   1     copy shadow -> active configuration
//   cfg_valid   out  1     active configuration is loaded
//   cfg_err     out  1     one-cycle pulse: commit rejected, too few bits shifted
// BEHAVIOUR
//   Reset (rst_n=0, async): shadow, active cfg, BLE FFs, bit counter = 0; out=0, scan_out=0,
//     cfg_valid=0, cfg_err=0.
//   Shift: scan_en=1 -> shadow <= {shadow[CFG_BITS-2:0], scan_in}; cnt <= min(cnt+1, CFG_BITS).
//   Shadow/active field map (bit positions), L=N*2**K, M=L+N*K*SEL_W:
//     LUT table of BLE b   [b*2**K +: 2**K]; LUT output = table[lut_in]
//     select of BLE b input k  [L+(b*K+k)*SEL_W +: SEL_W]
//     mode of BLE b        [M+b]      1=registered, 0=combinational
//     init of BLE b        [M+N+b]    FF value loaded at commit
//   Crossbar source s: s<I -> clb_in[s]; I<=s<I+N -> FF q of BLE (s-I); s>=I+N -> 1'b0.
//     Feedback is always taken from the FF, never the comb path: no combinational loops are possible.
//   Commit: cfg_commit=1 && scan_en=0 && cnt==CFG_BITS at edge t:
//     active <= shadow; each FF <= new init bit; cnt <= 0; cfg_valid <= 1 (visible after t).
//   Rejected commit: cfg_commit=1 && scan_en=0 && cnt<CFG_BITS ->
//     cfg_err=1 for exactly the next cycle; active cfg, cfg_valid and cnt are unchanged.
//   Commit with scan_en=1 -> commit ignored and no cfg_err; the shift happens.
//   cnt saturates: shifting more than CFG_BITS bits is legal; the last CFG_BITS bits shifted in are committed.
//   BLE FF: if a commit occurs, the commit load wins; else if ce && cfg_valid, q <= lut_out; else hold.
//   out[b] = cfg_valid ? (mode ? q : lut_out) : 0.
//     In combinational mode out is combinational from clb_in, with 0-cycle latency.
//     In registered mode out has 1-cycle latency.
//   Shifting while cfg_valid=1 does not disturb active cfg, out or FFs.
//   Reset mid-scan or mid-operation returns everything to the reset state immediately.
// TESTING
//   1 Reset: assert rst_n=0 -> out=0, scan_out=0, cfg_valid=0, cfg_err=0.
//     Shift 136 ones, assert rst_n=0 -> scan_out=0 at once.
//   2 Comb AND: BLE0 table=16'h8000, sels 0,1,2,3, mode0=0. Shift 136 bits, commit -> cfg_valid=1.
//     clb_in=10'h00F -> out[0]=1 same cycle; clb_in=10'h00E -> out[0]=0.
//   3 Registered toggle: BLE1 all four sels=11 (own FF), table bit0=1 bit15=0, mode1=1, init1=1.
//     After commit out[1]=1, then 0,1,0 on successive ce=1 edges; ce=0 holds the value.
//   4 Short commit: after reset, shift 100 bits, pulse commit -> cfg_err=1 for one cycle, cfg_valid=0.
//     Commit with scan_en=1 -> no cfg_err.
//   5 Live rescan: with test-2 config active, shift a new 136-bit stream -> out unchanged during the shift,
//     scan_out emits the old shadow MSB first; after commit the new function is active.
//   6 Ordering: commit and ce=1 on the same edge -> FF takes init, not lut_out.
//     Sel=15 (>=I+N) -> LUT input reads 0.

Source files
------------

// File: rtl/clb_multi_ble.sv
// clb_multi_ble: configurable logic block with CLB_BLE_NUM LUT-based logic elements.
// Each BLE is a LUT_K-input LUT. Its output is either combinational or taken from a
// flip-flop with a programmable init value. A full crossbar feeds every LUT input
// from the CLB inputs, from the BLE flip-flops, or from constant 0. Configuration is
// shifted into a shadow chain and then committed to the active configuration in one step.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clb_in [I]       user logic inputs
//   ce               clock enable for the BLE flip-flops
//   out [N]          BLE outputs, bit b comes from BLE b
//   scan_en/scan_in  shift the shadow chain by one bit per cycle
//   scan_out         chain serial output (MSB of the shadow chain)
//   cfg_commit       copy the shadow chain to the active configuration
//   cfg_valid        an active configuration has been loaded
//   cfg_err          one-cycle pulse when a commit is rejected
module clb_multi_ble #(
    parameter int unsigned CLB_IN_WIDTH = 10,
    parameter int unsigned CLB_BLE_NUM  = 4,
    parameter int unsigned LUT_K        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CLB_IN_WIDTH-1:0] clb_in,
    input  logic                    ce,
    output logic [CLB_BLE_NUM-1:0]  out,
    input  logic                    scan_en,
    input  logic                    scan_in,
    output logic                    scan_out,
    input  logic                    cfg_commit,
    output logic                    cfg_valid,
    output logic                    cfg_err
);
    localparam int unsigned I        = CLB_IN_WIDTH;
    localparam int unsigned N        = CLB_BLE_NUM;
    localparam int unsigned K        = LUT_K;
    localparam int unsigned TBL_W    = 1 << K;
    localparam int unsigned SEL_W    = $clog2(I + N + 1);
    localparam int unsigned SRC_W    = 1 << SEL_W;
    localparam int unsigned L        = N * TBL_W;
    localparam int unsigned M        = L + N * K * SEL_W;
    localparam int unsigned CFG_BITS = M + 2 * N;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CNT_W-1:0]    cnt;
    logic [N-1:0]        q;
    logic [N-1:0]        lut_out;
    logic [SRC_W-1:0]    src;
    logic                commit_ok;
    logic                commit_bad;
    logic                cnt_full;

    assign cnt_full   = (cnt == CNT_W'(CFG_BITS));
    assign commit_ok  = cfg_commit && !scan_en && cnt_full;
    assign commit_bad = cfg_commit && !scan_en && !cnt_full;
    assign scan_out   = shadow[CFG_BITS-1];

    // Crossbar source vector; unused upper sources stay at constant 0.
    always_comb begin
        src          = '0;
        src[I-1:0]   = clb_in;
        src[I +: N]  = q;
    end

    // Per-BLE input selection and LUT lookup from the active configuration.
    always_comb begin : lut_eval
        logic [TBL_W-1:0] tbl;
        logic [SEL_W-1:0] sel;
        logic [K-1:0]     lin;
        tbl     = '0;
        sel     = '0;
        lin     = '0;
        lut_out = '0;
        for (int b = 0; b < int'(N); b++) begin
            tbl = active[b*TBL_W +: TBL_W];
            for (int k = 0; k < int'(K); k++) begin
                sel    = active[L + (b*K + k)*SEL_W +: SEL_W];
                lin[k] = src[sel];
            end
            lut_out[b] = tbl[lin];
        end
    end

    // Registered BLEs select the FF, combinational ones the LUT; all gated by cfg_valid.
    assign out = cfg_valid ? ((active[M +: N] & q) | (~active[M +: N] & lut_out)) : '0;

    // Shadow chain, bit counter, active configuration and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            active    <= '0;
            cnt       <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= commit_bad;
            if (scan_en) begin
                shadow <= {shadow[CFG_BITS-2:0], scan_in};
                if (!cnt_full) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (commit_ok) begin
                active    <= shadow;
                cnt       <= '0;
                cfg_valid <= 1'b1;
            end
        end
    end

    // BLE flip-flops: a commit load takes priority over normal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (commit_ok) begin
            q <= shadow[M + N +: N];
        end else if (ce && cfg_valid) begin
            q <= lut_out;
        end
    end
endmodule

// File: tb/tb_clb_multi_ble.sv
// tb_clb_multi_ble: directed self-checking bench for clb_multi_ble (default parameters).
module tb_clb_multi_ble;
    localparam int unsigned I        = 10;
    localparam int unsigned N        = 4;
    localparam int unsigned K        = 4;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned L        = 64;
    localparam int unsigned M        = 128;
    localparam int unsigned CFG_BITS = 136;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [I-1:0]  clb_in;
    logic          ce;
    logic [N-1:0]  out;
    logic          scan_en;
    logic          scan_in;
    logic          scan_out;
    logic          cfg_commit;
    logic          cfg_valid;
    logic          cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [CFG_BITS-1:0] cfg;
    logic [CFG_BITS-1:0] cfg2;
    logic [CFG_BITS-1:0] cfg5;
    logic [CFG_BITS-1:0] cfg6;

    clb_multi_ble #(.CLB_IN_WIDTH(I), .CLB_BLE_NUM(N), .LUT_K(K)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clb_in     (clb_in),
        .ce         (ce),
        .out        (out),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .cfg_commit (cfg_commit),
        .cfg_valid  (cfg_valid),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tbl(input int b, input logic [15:0] v);
        cfg[b*16 +: 16] = v;
    endtask

    task automatic set_sel(input int b, input int k, input logic [SEL_W-1:0] s);
        cfg[L + (b*K + k)*SEL_W +: SEL_W] = s;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        clb_in     = '0;
        ce         = 1'b0;
        scan_en    = 1'b0;
        scan_in    = 1'b0;
        cfg_commit = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Shift a full stream MSB first; optionally check scan_out and out before each edge.
    task automatic shift_cfg(input logic [CFG_BITS-1:0] v, input bit chk,
                             input logic [CFG_BITS-1:0] old, input logic [N-1:0] exp_out);
        scan_en = 1'b1;
        for (int i = CFG_BITS - 1; i >= 0; i--) begin
            scan_in = v[i];
            if (chk) begin
                #1;
                check_eq("rescan_so", 32'(scan_out), 32'(old[i]));
                check_eq("rescan_out", 32'(out), 32'(exp_out));
            end
            tick();
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic shift_n(input int n, input logic bitv);
        scan_en = 1'b1;
        scan_in = bitv;
        for (int i = 0; i < n; i++) tick();
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        // Configuration images built by hand from the field map.
        cfg = '0;
        set_tbl(0, 16'h8000);
        for (int k = 0; k < 4; k++) set_sel(0, k, SEL_W'(k));
        cfg2 = cfg;

        cfg = '0;
        set_tbl(0, 16'h7FFF);
        for (int k = 0; k < 4; k++) set_sel(0, k, SEL_W'(k));
        cfg5 = cfg;

        cfg = '0;
        set_tbl(1, 16'h0001);
        for (int k = 0; k < 4; k++) set_sel(1, k, SEL_W'(11));
        cfg[M + 1]     = 1'b1;
        cfg[M + N + 1] = 1'b1;
        set_tbl(2, 16'h0001);
        for (int k = 0; k < 4; k++) set_sel(2, k, SEL_W'(15));
        cfg6 = cfg;

        // 1: reset state and async reset mid-scan
        rst_n = 1'b0; clb_in = '0; ce = 1'b0; scan_en = 1'b0; scan_in = 1'b0; cfg_commit = 1'b0;
        #1;
        check_eq("rst_out", 32'(out), 32'h0);
        check_eq("rst_so", 32'(scan_out), 32'h0);
        check_eq("rst_valid", 32'(cfg_valid), 32'h0);
        check_eq("rst_err", 32'(cfg_err), 32'h0);
        tick();
        rst_n = 1'b1;
        shift_n(136, 1'b1);
        check_eq("ones_so", 32'(scan_out), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("midscan_rst_so", 32'(scan_out), 32'h0);
        tick();
        rst_n = 1'b1;

        // 2: combinational AND in BLE0
        do_reset();
        shift_cfg(cfg2, 1'b0, '0, '0);
        commit();
        check_eq("and_valid", 32'(cfg_valid), 32'h1);
        clb_in = 10'h00F; #1;
        check_eq("and_f", 32'(out), 32'h1);
        clb_in = 10'h00E; #1;
        check_eq("and_e", 32'(out), 32'h0);
        clb_in = 10'h3FF; #1;
        check_eq("and_3ff", 32'(out), 32'h1);

        // 3: registered toggle in BLE1 (BLE2 constant-source LUT also loaded)
        do_reset();
        clb_in = 10'h3FF;
        shift_cfg(cfg6, 1'b0, '0, '0);
        commit();
        check_eq("tog_init", 32'(out), 32'h6);
        ce = 1'b1;
        tick(); check_eq("tog_1", 32'(out), 32'h4);
        tick(); check_eq("tog_2", 32'(out), 32'h6);
        tick(); check_eq("tog_3", 32'(out), 32'h4);
        ce = 1'b0;
        tick(); check_eq("tog_hold1", 32'(out), 32'h4);
        tick(); check_eq("tog_hold2", 32'(out), 32'h4);

        // 4: short commit rejected, commit during shift ignored
        do_reset();
        shift_n(100, 1'b0);
        commit();
        check_eq("short_err", 32'(cfg_err), 32'h1);
        check_eq("short_valid", 32'(cfg_valid), 32'h0);
        tick();
        check_eq("short_err_pulse", 32'(cfg_err), 32'h0);
        scan_en = 1'b1; cfg_commit = 1'b1;
        tick();
        check_eq("scan_commit_err", 32'(cfg_err), 32'h0);
        check_eq("scan_commit_valid", 32'(cfg_valid), 32'h0);
        scan_en = 1'b0; cfg_commit = 1'b0;
        tick();
        check_eq("scan_commit_err2", 32'(cfg_err), 32'h0);
        shift_n(35, 1'b0);
        commit();
        check_eq("full_commit_valid", 32'(cfg_valid), 32'h1);
        check_eq("full_commit_err", 32'(cfg_err), 32'h0);

        // 5: live rescan from the AND config to a NAND config
        do_reset();
        shift_cfg(cfg2, 1'b0, '0, '0);
        commit();
        clb_in = 10'h00F;
        shift_cfg(cfg5, 1'b1, cfg2, 4'h1);
        check_eq("rescan_valid", 32'(cfg_valid), 32'h1);
        commit();
        #1;
        check_eq("nand_f", 32'(out), 32'h0);
        clb_in = 10'h00E; #1;
        check_eq("nand_e", 32'(out), 32'h1);

        // 6: commit beats ce on the same edge; select 15 reads constant 0
        do_reset();
        clb_in = 10'h3FF;
        shift_cfg(cfg6, 1'b0, '0, '0);
        commit();
        check_eq("sel15_out", 32'(out), 32'h6);
        ce = 1'b1;
        tick(); check_eq("ord_pre0", 32'(out), 32'h4);
        tick(); check_eq("ord_pre1", 32'(out), 32'h6);
        ce = 1'b0;
        shift_n(4, 1'b1);
        shift_cfg(cfg6, 1'b0, '0, '0);
        check_eq("ord_hold", 32'(out), 32'h6);
        ce = 1'b1; cfg_commit = 1'b1;
        tick();
        ce = 1'b0; cfg_commit = 1'b0;
        check_eq("ord_commit_wins", 32'(out), 32'h6);
        check_eq("ord_err", 32'(cfg_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
